// File: rtl/vecgate_pkg.sv
// Shared widths, the result record and the vector-gate function used by vecgate_rr_sched.
package vecgate_pkg;

  localparam int VG_W     = 3;
  localparam int VG_N_REQ = 4;

  typedef logic [$clog2(VG_N_REQ)-1:0] vg_id_t;

  typedef struct packed {
    logic [VG_W-1:0]   or_bitwise;
    logic              or_logical;
    logic [2*VG_W-1:0] not_ab;
  } vg_result_t;

  function automatic vg_result_t vg_compute(input logic [VG_W-1:0] a, input logic [VG_W-1:0] b);
    vg_result_t r;
    r.or_bitwise = a | b;
    r.or_logical = (|a) | (|b);
    r.not_ab     = {~b, ~a};
    return r;
  endfunction

endpackage

// File: rtl/vecgate_rr_arb.sv
// Combinational round-robin search: first valid requester at or above ptr, wrapping to 0.
module vecgate_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_id
);

  always_comb begin
    int  idx;
    logic found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = (int'(ptr) + off) % N_REQ;
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/vecgate_rr_sched.sv
// Round-robin scheduler sharing one vector-gate unit; 1-cycle registered result with valid/ready.
// Optional per-requester accept counters on grant_cnt when VECGATE_GRANT_CNT_EN is defined.
module vecgate_rr_sched
  import vecgate_pkg::*;
#(
  parameter int W     = VG_W,
  parameter int N_REQ = VG_N_REQ
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W-1:0]   req_a,
  input  logic [N_REQ*W-1:0]   req_b,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N_REQ)-1:0] out_id,
  output logic [W-1:0]         out_or_bitwise,
  output logic                 out_or_logical,
  output logic [2*W-1:0]       out_not
`ifdef VECGATE_GRANT_CNT_EN
  ,
  output logic [N_REQ*16-1:0]  grant_cnt
`endif
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [IW-1:0] ID_MAX = IW'(N_REQ - 1);

  logic [IW-1:0]    rr_ptr;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    grant_id;
  logic             can_load;
  logic             accept;
  logic [W-1:0]     a_sel, b_sel;
  logic [W-1:0]     nx_or;
  logic             nx_lg;
  logic [2*W-1:0]   nx_not;

  vecgate_rr_arb #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req_valid (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  // Reset gating keeps req_ready low while rst is held, even though out_valid is already 0.
  assign can_load  = !out_valid | out_ready;
  assign req_ready = grant & {N_REQ{can_load & !flush & !rst}};
  assign accept    = |req_ready;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*W +: W];
        b_sel = req_b[i*W +: W];
      end
    end
  end

  generate
    if (W == VG_W) begin : g_pkg_fn
      vg_result_t res;
      assign res    = vg_compute(a_sel, b_sel);
      assign nx_or  = res.or_bitwise;
      assign nx_lg  = res.or_logical;
      assign nx_not = res.not_ab;
    end else begin : g_generic
      assign nx_or  = a_sel | b_sel;
      assign nx_lg  = (|a_sel) | (|b_sel);
      assign nx_not = {~b_sel, ~a_sel};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_id         <= '0;
      out_or_bitwise <= '0;
      out_or_logical <= 1'b0;
      out_not        <= '0;
      rr_ptr         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_id         <= grant_id;
      out_or_bitwise <= nx_or;
      out_or_logical <= nx_lg;
      out_not        <= nx_not;
      rr_ptr         <= (grant_id == ID_MAX) ? '0 : grant_id + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef VECGATE_GRANT_CNT_EN
  // Counters survive flush and wrap naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ready[i]) grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vecgate_rr_sched.sv
// Directed self-checking bench for vecgate_rr_sched (W=3, N_REQ=4).
module tb_vecgate_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_a, req_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_id;
  logic [2:0]  out_or_bitwise;
  logic        out_or_logical;
  logic [5:0]  out_not;
`ifdef VECGATE_GRANT_CNT_EN
  logic [63:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vecgate_rr_sched #(.W(3), .N_REQ(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_id         (out_id),
    .out_or_bitwise (out_or_bitwise),
    .out_or_logical (out_or_logical),
    .out_not        (out_not)
`ifdef VECGATE_GRANT_CNT_EN
    ,
    .grant_cnt      (grant_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'hF; req_a = '0; req_b = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_or_bitwise", out_or_bitwise, 0);
    chk("rst_out_not", out_not, 0);

    rst = 1'b0; #1;
    chk("first_grant", req_ready, 4'b0001);
    req_valid = 4'b0000;
    step();
    chk("idle_out_valid", out_valid, 0);

    // Single request from requester 2: a2=001, b2=100
    req_valid = 4'b0100; req_a = 12'h040; req_b = 12'h100; #1;
    chk("single_ready", req_ready, 4'b0100);
    step();
    req_valid = 4'b0000;
    chk("single_valid", out_valid, 1);
    chk("single_id", out_id, 2);
    chk("single_or_bw", out_or_bitwise, 3'b101);
    chk("single_or_lg", out_or_logical, 1);
    chk("single_not", out_not, 6'b011110);

    // Requester 3 alone: a3=111, b3=000; moves the pointer back to 0
    req_valid = 4'b1000; req_a = 12'hE00; req_b = 12'h000; #1;
    chk("r3_ready", req_ready, 4'b1000);
    step();
    req_valid = 4'b0000;
    chk("r3_id", out_id, 3);
    chk("r3_or_bw", out_or_bitwise, 3'b111);
    chk("r3_not", out_not, 6'b111000);

    // All valid, slice i of a holds value i
    req_valid = 4'hF; req_a = 12'h688; req_b = 12'h000;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_valid", out_valid, 1);
      chk("rr_id", out_id, k % 4);
      chk("rr_or_bw", out_or_bitwise, k % 4);
    end

    // Stall with all requesters waiting
    out_ready = 1'b0; #1;
    chk("stall_ready0", req_ready, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_ready", req_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_id", out_id, 3);
      chk("stall_or_bw", out_or_bitwise, 3);
    end

    flush = 1'b1; #1;
    chk("flush_ready", req_ready, 0);
    step();
    flush = 1'b0;
    chk("flush_valid", out_valid, 0);
    out_ready = 1'b1; #1;
    chk("flush_ptr_hold", req_ready, 4'b0001);

    // Zero operands on requester 0
    req_valid = 4'b0001; req_a = '0; req_b = '0;
    step();
    req_valid = 4'b0000;
    chk("zero_valid", out_valid, 1);
    chk("zero_id", out_id, 0);
    chk("zero_or_bw", out_or_bitwise, 0);
    chk("zero_or_lg", out_or_logical, 0);
    chk("zero_not", out_not, 6'b111111);

    out_ready = 1'b0; rst = 1'b1; #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", req_ready, 0);
    chk("async_rst_not", out_not, 0);

`ifdef VECGATE_GRANT_CNT_EN
    step();
    rst = 1'b0; out_ready = 1'b1; req_valid = 4'b0010;
    repeat (65535) @(posedge clk);
    #1;
    chk("cnt1_full", grant_cnt[31:16], 16'hFFFF);
    chk("cnt0_zero", grant_cnt[15:0], 0);
    step();
    req_valid = 4'b0000;
    chk("cnt1_wrap", grant_cnt[31:16], 0);
    chk("cnt_others", {grant_cnt[63:32], grant_cnt[15:0]}, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
